// File: rtl/counter19_ctrl.sv
// Run/pause/clear sequencer for the 0..MAX_COUNT counter lab.
// It owns the count register and scans the converter's BCD digits onto one shared segment decoder.
module counter19_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int SCAN_DIV  = 10,
  parameter int MAX_COUNT = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic [4:0] bin,
  output logic [3:0] seg_bcd,
  output logic [1:0] dig_en,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  SCAN_LAST = 8'(SCAN_DIV - 1);
  localparam logic [4:0]  COUNT_MAX = 5'(MAX_COUNT);

  state_t      state, state_next;
  logic [2:0]  ss_sync, clr_sync;
  logic        ss_p, clr_p;
  logic        advance, tick;
  logic [15:0] prescale;
  logic [7:0]  scan_cnt;
  logic        sel;

  // Bits [1:0] form the synchronizer; bit [2] is the previous stage-2 value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync  <= '0;
      clr_sync <= '0;
    end else begin
      ss_sync  <= {ss_sync[1:0], btn_ss};
      clr_sync <= {clr_sync[1:0], btn_clr};
    end
  end

  assign ss_p  = ss_sync[1] & ~ss_sync[2];
  assign clr_p = clr_sync[1] & ~clr_sync[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr_p) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (ss_p) state_next = RUN;
        RUN:     if (ss_p) state_next = PAUSE;
        PAUSE:   if (ss_p) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);

  // A start/stop pulse in RUN freezes the prescaler in that same cycle, so PAUSE holds the phase seen at the press.
  assign advance = (state == RUN) && !ss_p && !clr_p;
  assign tick    = advance && (prescale == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      bin      <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p || state == IDLE) begin
        prescale <= '0;
        bin      <= '0;
      end else if (advance) begin
        if (tick) begin
          prescale <= '0;
          if (bin == COUNT_MAX) begin
            bin  <= '0;
            wrap <= 1'b1;
          end else begin
            bin <= bin + 5'd1;
          end
        end else begin
          prescale <= prescale + 16'd1;
        end
      end
    end
  end

  // Outputs follow sel one edge later, so the first ones slot after reset lasts the full SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
      seg_bcd  <= '0;
      dig_en   <= 2'b11;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + 8'd1;
      end
      if (sel) begin
        seg_bcd <= bcd_tens;
        dig_en  <= (bcd_tens == 4'd0) ? 2'b11 : 2'b01;
      end else begin
        seg_bcd <= bcd_ones;
        dig_en  <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_counter19_ctrl.sv
// Directed bench for counter19_ctrl with TICK_DIV=4, SCAN_DIV=2.
// A behavioural binary-to-BCD converter closes the loop from bin to the digit inputs.
module tb_counter19_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_clr;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [4:0] bin;
  logic [3:0] seg_bcd;
  logic [1:0] dig_en;
  logic       running;
  logic       wrap;

  int compared   = 0;
  int mismatched = 0;

  counter19_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .MAX_COUNT(19)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_clr  (btn_clr),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .bin      (bin),
    .seg_bcd  (seg_bcd),
    .dig_en   (dig_en),
    .running  (running),
    .wrap     (wrap)
  );

  assign bcd_tens = 4'(bin / 5'd10);
  assign bcd_ones = 4'(bin % 5'd10);

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ss, input logic clr);
    btn_ss  = ss;
    btn_clr = clr;
  endtask

  // Sampling and driving both happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitBin(input int value, input int budget, input string tag);
    int n = 0;
    while (int'(bin) != value && n < budget) begin
      step();
      n++;
    end
    checkOutput(tag, int'(bin), value);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("reset bin", int'(bin), 0);
      checkOutput("reset running", int'(running), 0);
      checkOutput("reset dig_en", int'(dig_en), 3);
      checkOutput("reset wrap", int'(wrap), 0);
    end
    rst = 1'b0;

    // Ones slot for two edges, then blanked tens slot for two edges.
    step(); checkOutput("scan1 dig_en", int'(dig_en), 2); checkOutput("scan1 seg", int'(seg_bcd), 0);
    step(); checkOutput("scan2 dig_en", int'(dig_en), 2);
    step(); checkOutput("scan3 dig_en", int'(dig_en), 3); checkOutput("scan3 seg", int'(seg_bcd), 0);
    step(); checkOutput("scan4 dig_en", int'(dig_en), 3);

    applyStimulus(1'b1, 1'b0);
    step(); checkOutput("start edge1 running", int'(running), 0);
    applyStimulus(1'b0, 1'b0);
    step(); checkOutput("start edge2 running", int'(running), 0);
    step(); checkOutput("start edge3 running", int'(running), 1);
    repeat (3) step();
    checkOutput("first step pending bin", int'(bin), 0);
    step(); checkOutput("first step bin", int'(bin), 1);
    repeat (35) step();
    checkOutput("before ten bin", int'(bin), 9);
    step(); checkOutput("ten bin", int'(bin), 10);

    step();
    for (int i = 0; i < 4 && dig_en == 2'b10; i++) step();
    checkOutput("ten tens dig_en", int'(dig_en), 1);
    checkOutput("ten tens seg", int'(seg_bcd), 1);

    waitBin(19, 60, "reach 19");
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("wrap window bin", int'(bin), (k < 4) ? 19 : (k < 8) ? 0 : 1);
      checkOutput("wrap window pulse", int'(wrap), (k == 4) ? 1 : 0);
    end

    waitBin(8, 40, "reach 8");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    step(); checkOutput("pause pulse cycle running", int'(running), 1);
    step(); checkOutput("paused running", int'(running), 0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("paused bin", int'(bin), 8);
      step();
    end
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    step();
    step(); checkOutput("resume running", int'(running), 1); checkOutput("resume bin", int'(bin), 8);
    step(); checkOutput("resume+1 bin", int'(bin), 8);
    step(); checkOutput("resume+2 bin", int'(bin), 9);

    waitBin(13, 30, "reach 13");
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1);
    step(); checkOutput("clr pulse cycle bin", int'(bin), 13);
    step(); checkOutput("clr running", int'(running), 0); checkOutput("clr bin", int'(bin), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("clr held running", int'(running), 0);
      checkOutput("clr held bin", int'(bin), 0);
    end
    applyStimulus(1'b0, 1'b0);

    // A restart from IDLE must take the full four clocks to the first step.
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    step();
    step(); checkOutput("restart running", int'(running), 1);
    repeat (3) step();
    checkOutput("restart pending bin", int'(bin), 0);
    step(); checkOutput("restart first bin", int'(bin), 1);

    waitBin(17, 80, "reach 17");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst bin", int'(bin), 0);
    checkOutput("async rst dig_en", int'(dig_en), 3);
    checkOutput("async rst running", int'(running), 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checkOutput("post rst running", int'(running), 0);
      checkOutput("post rst bin", int'(bin), 0);
    end
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    step();
    step(); checkOutput("post rst start running", int'(running), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
